axi4_mem_responder: RTL and testbench
=====================================

# axi4_mem_responder

AXI4 slave-side responder backed by an internal word-addressed memory. It terminates AW/W/B and AR/R transactions issued by an AXI4 initiator, or by the network-side depacketizer that rebuilds AXI channels (tags CHANNEL_AW/W/B/AR/R). It has independent write and read engines and supports FIXED, INCR and WRAP bursts. It is the default memory endpoint for NoC AXI4 bring-up and regression.

## Interface
- DEPTH, 1024: memory depth in DATA_WIDTH words; index = addr[ADDR_WIDTH-1:3]
- ADDR_WIDTH / DATA_WIDTH / ID_WIDTH: taken from axi4_pkg (32 / 64 / 8)
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- awid, awaddr, awlen, awsize, awburst  in  axi_id_t/addr_t/len_t/size_t/burst_t  write address
- awvalid in 1; awready out 1
- wdata, wstrb, wlast  in  axi_data_t/axi_strb_t/1  write data
- wvalid in 1; wready out 1
- bid out axi_id_t; bresp out axi_resp_t; bvalid out 1; bready in 1
- arid, araddr, arlen, arsize, arburst  in  as AW  read address
- arvalid in 1; arready out 1
- rid out axi_id_t; rdata out axi_data_t; rresp out axi_resp_t; rlast out 1; rvalid out 1; rready in 1

## Operation
- Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
  - W_IDLE: awready=1. On awvalid, latch id/addr/len/size/burst, clear beat count and err flag, go to W_DATA.
  - W_DATA: wready=1. On each wvalid beat, write the bytes enabled by wstrb to mem[index] when index < DEPTH; otherwise set err. Advance the address and count the beat.
  - wlast asserted on a beat other than beat awlen sets err.
  - Leave W_DATA on the beat whose count == awlen, regardless of wlast.
  - W_RESP: bvalid=1, bid = latched id, bresp = err ? RESP_SLVERR : RESP_OKAY. On bready, return to W_IDLE.
- Read FSM R_IDLE -> R_DATA -> R_IDLE.
  - R_IDLE: arready=1. On arvalid, latch fields and load the beat-0 word into rdata.
  - R_DATA: rvalid=1, rid = latched id, rlast = (count == arlen).
  - Out-of-range beat: rdata=0, rresp=RESP_SLVERR. In-range beat: rresp=RESP_OKAY.
  - On rready, load the next beat, or return to R_IDLE after the last beat.
- Address update, with incr = 1 << size:
  - FIXED: address unchanged.
  - INCR: addr + incr, modulo 2^ADDR_WIDTH.
  - WRAP: bound = (len+1)*incr; next = (addr & ~(bound-1)) | ((addr+incr) & (bound-1)).
- A WRAP burst with len not in {1,3,7,15}, or any burst type 2'b11, still executes address-FIXED and responds SLVERR on every beat (read) or in B (write). Writes still occur for in-range beats.
- Size is not used to mask strobes. Reads always return the full word.
- awsize/arsize > AXSIZE_8 is treated as AXSIZE_8 for the address increment.
- Memory contents are not reset.

## Timing
- Reset: awready=arready=wready=0, bvalid=rvalid=rlast=0, bid/rid/bresp/rresp/rdata=0. FSMs go to IDLE. awready/arready rise in the first cycle after rst deasserts.
- rst mid-transaction abandons it immediately. No B or R is issued for it, and memory writes already performed remain.
- AW handshake at cycle N: wready=1 from N+1. One beat per cycle. Last beat at M gives bvalid from M+1.
- bvalid holds with stable bid/bresp until bready. The next AW is accepted no earlier than the cycle after the B handshake.
- AR handshake at N: rvalid=1 with beat 0 at N+1.
- With rready held high, beats are back-to-back, one per cycle. rvalid/rdata/rresp/rlast are stable while rready=0.
- Read-write collision: a read beat loaded at the same edge a write updates that word returns the pre-write contents.
- AW and AR engines are independent and may be active simultaneously.
- awready/arready/wready are decoded from state. All other outputs are registered.

## Test plan
- Reset values: hold rst 3 cycles -> every output is 0. Cycle after release -> awready=1, arready=1.
- INCR write then read: AW addr 0x100, len 3, size AXSIZE_8; W 0xA0..0xA3 with full strobes -> bresp OKAY one cycle after wlast. AR same address -> rdata A0,A1,A2,A3 at N+1..N+4, rlast on the 4th beat, rresp OKAY.
- WRAP plus strobes: AW addr 0x18, len 3, WRAP, wstrb 0x0F -> words at 0x18,0x00,0x08,0x10 get their low 32 bits written. INCR read from 0x00 confirms the order and that the upper bytes are unchanged.
- Error paths:
  - Read at index DEPTH -> rdata 0, rresp SLVERR.
  - Write len 1 with wlast on beat 0 -> bresp SLVERR.
  - WRAP with len 2 -> SLVERR.
- Backpressure: during a len-7 read, toggle rready randomly -> no beat lost or duplicated and outputs stable while stalled. Holding bready=0 for 10 cycles keeps bvalid high with bresp stable.
- Concurrency and reset: overlapping write to word 5 and read of word 5 -> read returns old data. Assert rst mid-burst -> no B/R is issued and both ready signals return high afterwards.

Source files
------------

// File: rtl/axi4_mem_responder_if.sv
// AXI4 channel bundle between an initiator (master) and the memory responder (slave).
// Widths: 32-bit address, 64-bit data, 8-bit ID.
interface axi4_mem_responder_if;
    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 64;
    localparam int ID_WIDTH   = 8;
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic [ID_WIDTH-1:0]   awid;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic                  awvalid;
    logic                  awready;

    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready;

    logic [ID_WIDTH-1:0]   bid;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;

    logic [ID_WIDTH-1:0]   arid;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arvalid;
    logic                  arready;

    logic [ID_WIDTH-1:0]   rid;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );
endinterface

// File: rtl/axi4_mem_responder.sv
// AXI4 slave terminating AW/W/B and AR/R into an internal word-addressed memory,
// with independent write and read engines and FIXED/INCR/WRAP burst support.
module axi4_mem_responder #(
    parameter int DEPTH = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    axi4_mem_responder_if.slave   bus
);
    localparam int AW     = 32;
    localparam int DW     = 64;
    localparam int IW     = 8;
    localparam int SW     = DW / 8;
    localparam int WORD_W = AW - 3;
    localparam int MEM_AW = $clog2(DEPTH);

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [WORD_W-1:0] DEPTH_WORDS = WORD_W'(DEPTH);

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_e;
    typedef enum logic       {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_e;

    // Illegal WRAP lengths and the reserved burst type run address-FIXED and respond SLVERR.
    function automatic logic burst_bad(input logic [7:0] len, input logic [1:0] burst);
        logic bad;
        case (burst)
            BURST_WRAP: bad = !((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15));
            BURST_RSVD: bad = 1'b1;
            default:    bad = 1'b0;
        endcase
        return bad;
    endfunction

    function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] addr, input logic [7:0] len,
                                                input logic [2:0] size, input logic [1:0] burst);
        logic [2:0]    size_eff;
        logic [AW-1:0] incr;
        logic [AW-1:0] bound;
        logic [AW-1:0] nxt;
        size_eff = (size > 3'd3) ? 3'd3 : size;
        incr     = 32'd1 << size_eff;
        bound    = ({24'd0, len} + 32'd1) * incr;
        case (burst)
            BURST_FIXED: nxt = addr;
            BURST_INCR:  nxt = addr + incr;
            BURST_WRAP:  nxt = burst_bad(len, burst) ? addr :
                               ((addr & ~(bound - 32'd1)) | ((addr + incr) & (bound - 32'd1)));
            default:     nxt = addr;
        endcase
        return nxt;
    endfunction

    logic [DW-1:0] mem [DEPTH];

    w_state_e        w_state_q, w_state_d;
    logic [IW-1:0]   aw_id_q, aw_id_d;
    logic [AW-1:0]   aw_addr_q, aw_addr_d;
    logic [7:0]      aw_len_q, aw_len_d;
    logic [2:0]      aw_size_q, aw_size_d;
    logic [1:0]      aw_burst_q, aw_burst_d;
    logic [7:0]      w_cnt_q, w_cnt_d;
    logic            w_err_q, w_err_d;
    logic [IW-1:0]   bid_q, bid_d;
    logic [1:0]      bresp_q, bresp_d;
    logic            bvalid_q, bvalid_d;
    logic [WORD_W-1:0] w_word_s;
    logic            w_in_range_s;
    logic            w_beat_err_s;
    logic            mem_we_s;

    r_state_e        r_state_q, r_state_d;
    logic [IW-1:0]   ar_id_q, ar_id_d;
    logic [AW-1:0]   ar_addr_q, ar_addr_d;
    logic [7:0]      ar_len_q, ar_len_d;
    logic [2:0]      ar_size_q, ar_size_d;
    logic [1:0]      ar_burst_q, ar_burst_d;
    logic [7:0]      r_cnt_q, r_cnt_d;
    logic [IW-1:0]   rid_q, rid_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic [1:0]      rresp_q, rresp_d;
    logic            rlast_q, rlast_d;
    logic            rvalid_q, rvalid_d;
    logic [AW-1:0]   r_fetch_addr_s;
    logic [WORD_W-1:0] r_word_s;
    logic            r_in_range_s;
    logic [DW-1:0]   r_mem_word_s;

    // Ready signals come straight from engine state, held low while reset is asserted.
    always_comb begin
        bus.awready = (w_state_q == W_IDLE) && !rst;
        bus.wready  = (w_state_q == W_DATA) && !rst;
        bus.arready = (r_state_q == R_IDLE) && !rst;
    end

    assign bus.bid    = bid_q;
    assign bus.bresp  = bresp_q;
    assign bus.bvalid = bvalid_q;
    assign bus.rid    = rid_q;
    assign bus.rdata  = rdata_q;
    assign bus.rresp  = rresp_q;
    assign bus.rlast  = rlast_q;
    assign bus.rvalid = rvalid_q;

    // Write engine next-state: AW latch, data beats with byte strobes, then B response.
    always_comb begin
        w_state_d    = w_state_q;
        aw_id_d      = aw_id_q;
        aw_addr_d    = aw_addr_q;
        aw_len_d     = aw_len_q;
        aw_size_d    = aw_size_q;
        aw_burst_d   = aw_burst_q;
        w_cnt_d      = w_cnt_q;
        w_err_d      = w_err_q;
        bid_d        = bid_q;
        bresp_d      = bresp_q;
        bvalid_d     = bvalid_q;
        mem_we_s     = 1'b0;
        w_word_s     = aw_addr_q[AW-1:3];
        w_in_range_s = (w_word_s < DEPTH_WORDS);
        w_beat_err_s = !w_in_range_s || (bus.wlast && (w_cnt_q != aw_len_q));
        case (w_state_q)
            W_IDLE: begin
                if (bus.awvalid) begin
                    aw_id_d    = bus.awid;
                    aw_addr_d  = bus.awaddr;
                    aw_len_d   = bus.awlen;
                    aw_size_d  = bus.awsize;
                    aw_burst_d = bus.awburst;
                    w_cnt_d    = 8'd0;
                    w_err_d    = 1'b0;
                    w_state_d  = W_DATA;
                end else begin
                    w_state_d  = W_IDLE;
                end
            end
            W_DATA: begin
                if (bus.wvalid) begin
                    mem_we_s  = w_in_range_s;
                    w_err_d   = w_err_q || w_beat_err_s;
                    aw_addr_d = next_addr(aw_addr_q, aw_len_q, aw_size_q, aw_burst_q);
                    w_cnt_d   = w_cnt_q + 8'd1;
                    if (w_cnt_q == aw_len_q) begin
                        w_state_d = W_RESP;
                        bvalid_d  = 1'b1;
                        bid_d     = aw_id_q;
                        bresp_d   = (w_err_q || w_beat_err_s || burst_bad(aw_len_q, aw_burst_q)) ?
                                    RESP_SLVERR : RESP_OKAY;
                    end else begin
                        w_state_d = W_DATA;
                    end
                end else begin
                    mem_we_s = 1'b0;
                end
            end
            W_RESP: begin
                if (bus.bready) begin
                    w_state_d = W_IDLE;
                    bvalid_d  = 1'b0;
                end else begin
                    bvalid_d  = 1'b1;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Write engine registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_q  <= W_IDLE;
            aw_id_q    <= 8'd0;
            aw_addr_q  <= 32'd0;
            aw_len_q   <= 8'd0;
            aw_size_q  <= 3'd0;
            aw_burst_q <= 2'd0;
            w_cnt_q    <= 8'd0;
            w_err_q    <= 1'b0;
            bid_q      <= 8'd0;
            bresp_q    <= 2'd0;
            bvalid_q   <= 1'b0;
        end else begin
            w_state_q  <= w_state_d;
            aw_id_q    <= aw_id_d;
            aw_addr_q  <= aw_addr_d;
            aw_len_q   <= aw_len_d;
            aw_size_q  <= aw_size_d;
            aw_burst_q <= aw_burst_d;
            w_cnt_q    <= w_cnt_d;
            w_err_q    <= w_err_d;
            bid_q      <= bid_d;
            bresp_q    <= bresp_d;
            bvalid_q   <= bvalid_d;
        end
    end

    // Byte-enabled memory write; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (!rst && mem_we_s) begin
            for (int b = 0; b < SW; b++) begin
                if (bus.wstrb[b]) begin
                    mem[w_word_s[MEM_AW-1:0]][b*8 +: 8] <= bus.wdata[b*8 +: 8];
                end
            end
        end
    end

    // Read engine next-state: the beat word is fetched from the address being loaded,
    // so a same-edge write to that word is not yet visible.
    always_comb begin
        r_state_d      = r_state_q;
        ar_id_d        = ar_id_q;
        ar_addr_d      = ar_addr_q;
        ar_len_d       = ar_len_q;
        ar_size_d      = ar_size_q;
        ar_burst_d     = ar_burst_q;
        r_cnt_d        = r_cnt_q;
        rid_d          = rid_q;
        rdata_d        = rdata_q;
        rresp_d        = rresp_q;
        rlast_d        = rlast_q;
        rvalid_d       = rvalid_q;
        r_fetch_addr_s = (r_state_q == R_IDLE) ? bus.araddr :
                         next_addr(ar_addr_q, ar_len_q, ar_size_q, ar_burst_q);
        r_word_s       = r_fetch_addr_s[AW-1:3];
        r_in_range_s   = (r_word_s < DEPTH_WORDS);
        r_mem_word_s   = r_in_range_s ? mem[r_word_s[MEM_AW-1:0]] : {DW{1'b0}};
        case (r_state_q)
            R_IDLE: begin
                if (bus.arvalid) begin
                    ar_id_d    = bus.arid;
                    ar_addr_d  = bus.araddr;
                    ar_len_d   = bus.arlen;
                    ar_size_d  = bus.arsize;
                    ar_burst_d = bus.arburst;
                    r_cnt_d    = 8'd0;
                    rid_d      = bus.arid;
                    rdata_d    = r_mem_word_s;
                    rresp_d    = (!r_in_range_s || burst_bad(bus.arlen, bus.arburst)) ?
                                 RESP_SLVERR : RESP_OKAY;
                    rlast_d    = (bus.arlen == 8'd0);
                    rvalid_d   = 1'b1;
                    r_state_d  = R_DATA;
                end else begin
                    r_state_d  = R_IDLE;
                end
            end
            R_DATA: begin
                if (bus.rready) begin
                    if (rlast_q) begin
                        r_state_d = R_IDLE;
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                    end else begin
                        ar_addr_d = r_fetch_addr_s;
                        r_cnt_d   = r_cnt_q + 8'd1;
                        rdata_d   = r_mem_word_s;
                        rresp_d   = (!r_in_range_s || burst_bad(ar_len_q, ar_burst_q)) ?
                                    RESP_SLVERR : RESP_OKAY;
                        rlast_d   = ((r_cnt_q + 8'd1) == ar_len_q);
                    end
                end else begin
                    r_state_d = R_DATA;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // Read engine registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q  <= R_IDLE;
            ar_id_q    <= 8'd0;
            ar_addr_q  <= 32'd0;
            ar_len_q   <= 8'd0;
            ar_size_q  <= 3'd0;
            ar_burst_q <= 2'd0;
            r_cnt_q    <= 8'd0;
            rid_q      <= 8'd0;
            rdata_q    <= 64'd0;
            rresp_q    <= 2'd0;
            rlast_q    <= 1'b0;
            rvalid_q   <= 1'b0;
        end else begin
            r_state_q  <= r_state_d;
            ar_id_q    <= ar_id_d;
            ar_addr_q  <= ar_addr_d;
            ar_len_q   <= ar_len_d;
            ar_size_q  <= ar_size_d;
            ar_burst_q <= ar_burst_d;
            r_cnt_q    <= r_cnt_d;
            rid_q      <= rid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            rlast_q    <= rlast_d;
            rvalid_q   <= rvalid_d;
        end
    end
endmodule

// File: tb/tb_axi4_mem_responder.sv
// Directed bench for axi4_mem_responder: bursts, strobes, error responses,
// backpressure, read/write collision and mid-burst reset.
module tb_axi4_mem_responder;
    localparam logic [1:0] FIXED  = 2'b00;
    localparam logic [1:0] INCR   = 2'b01;
    localparam logic [1:0] WRAP   = 2'b10;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [63:0] exp_q [16];

    always #5 clk = ~clk;

    axi4_mem_responder_if bus ();

    axi4_mem_responder #(.DEPTH(1024)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_idle();
        bus.awid = 8'd0; bus.awaddr = 32'd0; bus.awlen = 8'd0; bus.awsize = 3'd0;
        bus.awburst = 2'd0; bus.awvalid = 1'b0;
        bus.wdata = 64'd0; bus.wstrb = 8'd0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
        bus.bready = 1'b0;
        bus.arid = 8'd0; bus.araddr = 32'd0; bus.arlen = 8'd0; bus.arsize = 3'd0;
        bus.arburst = 2'd0; bus.arvalid = 1'b0;
        bus.rready = 1'b0;
    endtask

    task automatic axi_write(input string tag, input logic [7:0] id, input logic [31:0] addr,
                             input logic [7:0] len, input logic [1:0] burst,
                             input logic [63:0] base, input logic [7:0] strb,
                             input int last_beat, input int hold, input logic [1:0] exp_resp);
        int n;
        @(negedge clk);
        bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awsize = 3'd3;
        bus.awburst = burst; bus.awvalid = 1'b1;
        n = 0;
        while (bus.awready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, " awready"}, {63'd0, bus.awready}, 64'd1);
        @(posedge clk); #1;
        bus.awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            bus.wvalid = 1'b1;
            bus.wdata  = base + 64'(i);
            bus.wstrb  = strb;
            bus.wlast  = (i == last_beat);
            @(negedge clk);
            check({tag, " wready"}, {63'd0, bus.wready}, 64'd1);
            @(posedge clk); #1;
        end
        bus.wvalid = 1'b0;
        bus.wlast  = 1'b0;
        @(negedge clk);
        check({tag, " bvalid"}, {63'd0, bus.bvalid}, 64'd1);
        check({tag, " bid"}, {56'd0, bus.bid}, {56'd0, id});
        check({tag, " bresp"}, {62'd0, bus.bresp}, {62'd0, exp_resp});
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({tag, " bvalid held"}, {63'd0, bus.bvalid}, 64'd1);
            check({tag, " bresp held"}, {62'd0, bus.bresp}, {62'd0, exp_resp});
        end
        bus.bready = 1'b1;
        @(posedge clk); #1;
        bus.bready = 1'b0;
        @(negedge clk);
        check({tag, " bvalid drop"}, {63'd0, bus.bvalid}, 64'd0);
    endtask

    task automatic axi_read(input string tag, input logic [7:0] id, input logic [31:0] addr,
                            input logic [7:0] len, input logic [1:0] burst,
                            input logic [1:0] exp_resp);
        int n;
        @(negedge clk);
        bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arsize = 3'd3;
        bus.arburst = burst; bus.arvalid = 1'b1;
        n = 0;
        while (bus.arready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, " arready"}, {63'd0, bus.arready}, 64'd1);
        @(posedge clk); #1;
        bus.arvalid = 1'b0;
        bus.rready  = 1'b1;
        for (int i = 0; i <= int'(len); i++) begin
            @(negedge clk);
            check({tag, " rvalid"}, {63'd0, bus.rvalid}, 64'd1);
            check({tag, " rdata"}, bus.rdata, exp_q[i]);
            check({tag, " rresp"}, {62'd0, bus.rresp}, {62'd0, exp_resp});
            check({tag, " rlast"}, {63'd0, bus.rlast}, {63'd0, (i == int'(len))});
            check({tag, " rid"}, {56'd0, bus.rid}, {56'd0, id});
            @(posedge clk); #1;
        end
        bus.rready = 1'b0;
        @(negedge clk);
        check({tag, " rvalid drop"}, {63'd0, bus.rvalid}, 64'd0);
    endtask

    initial begin
        int beat;
        int cyc;
        logic hs;

        drive_idle();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst awready", {63'd0, bus.awready}, 64'd0);
        check("rst arready", {63'd0, bus.arready}, 64'd0);
        check("rst wready", {63'd0, bus.wready}, 64'd0);
        check("rst bvalid", {63'd0, bus.bvalid}, 64'd0);
        check("rst rvalid", {63'd0, bus.rvalid}, 64'd0);
        check("rst rlast", {63'd0, bus.rlast}, 64'd0);
        check("rst bid", {56'd0, bus.bid}, 64'd0);
        check("rst rid", {56'd0, bus.rid}, 64'd0);
        check("rst bresp", {62'd0, bus.bresp}, 64'd0);
        check("rst rresp", {62'd0, bus.rresp}, 64'd0);
        check("rst rdata", bus.rdata, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post-rst awready", {63'd0, bus.awready}, 64'd1);
        check("post-rst arready", {63'd0, bus.arready}, 64'd1);

        // INCR write then read back
        axi_write("incr wr", 8'h11, 32'h100, 8'd3, INCR, 64'hA0, 8'hFF, 3, 0, OKAY);
        exp_q[0] = 64'hA0; exp_q[1] = 64'hA1; exp_q[2] = 64'hA2; exp_q[3] = 64'hA3;
        axi_read("incr rd", 8'h22, 32'h100, 8'd3, INCR, OKAY);

        // Prefill words 0..7, then WRAP write of low halves starting at 0x18
        axi_write("prefill", 8'h01, 32'h0, 8'd7, INCR, 64'hFFFF_FFFF_0000_0000, 8'hFF, 7, 0, OKAY);
        axi_write("wrap wr", 8'h33, 32'h18, 8'd3, WRAP, 64'hDEAD_BEEF_C000_0000, 8'h0F, 3, 0, OKAY);
        exp_q[0] = 64'hFFFF_FFFF_C000_0001; exp_q[1] = 64'hFFFF_FFFF_C000_0002;
        exp_q[2] = 64'hFFFF_FFFF_C000_0003; exp_q[3] = 64'hFFFF_FFFF_C000_0000;
        axi_read("wrap chk", 8'h44, 32'h0, 8'd3, INCR, OKAY);

        // Error paths
        exp_q[0] = 64'd0;
        axi_read("oor rd", 8'h55, 32'h2000, 8'd0, INCR, SLVERR);
        axi_write("early wlast", 8'h66, 32'h200, 8'd1, INCR, 64'h1234, 8'hFF, 0, 0, SLVERR);
        exp_q[0] = 64'hA0; exp_q[1] = 64'hA0; exp_q[2] = 64'hA0;
        axi_read("bad wrap rd", 8'h77, 32'h100, 8'd2, WRAP, SLVERR);
        axi_write("bad wrap wr", 8'h88, 32'h300, 8'd2, WRAP, 64'h77, 8'hFF, 2, 10, SLVERR);

        // Backpressure on a len-7 read
        exp_q[0] = 64'hFFFF_FFFF_C000_0001; exp_q[1] = 64'hFFFF_FFFF_C000_0002;
        exp_q[2] = 64'hFFFF_FFFF_C000_0003; exp_q[3] = 64'hFFFF_FFFF_C000_0000;
        exp_q[4] = 64'hFFFF_FFFF_0000_0004; exp_q[5] = 64'hFFFF_FFFF_0000_0005;
        exp_q[6] = 64'hFFFF_FFFF_0000_0006; exp_q[7] = 64'hFFFF_FFFF_0000_0007;
        @(negedge clk);
        bus.arid = 8'h99; bus.araddr = 32'h0; bus.arlen = 8'd7; bus.arsize = 3'd3;
        bus.arburst = INCR; bus.arvalid = 1'b1;
        check("bp arready", {63'd0, bus.arready}, 64'd1);
        @(posedge clk); #1;
        bus.arvalid = 1'b0;
        beat = 0;
        cyc = 0;
        while (beat < 8 && cyc < 300) begin
            @(negedge clk);
            bus.rready = 1'($urandom_range(0, 1));
            check("bp rvalid", {63'd0, bus.rvalid}, 64'd1);
            check("bp rdata", bus.rdata, exp_q[beat]);
            check("bp rlast", {63'd0, bus.rlast}, {63'd0, (beat == 7)});
            hs = bus.rvalid && bus.rready;
            @(posedge clk); #1;
            if (hs) beat++;
            cyc++;
        end
        check("bp beats", 64'(beat), 64'd8);
        bus.rready = 1'b0;
        @(negedge clk);
        check("bp rvalid drop", {63'd0, bus.rvalid}, 64'd0);

        // Write and read of word 5 on the same edge: read sees old data
        @(negedge clk);
        bus.awid = 8'hAB; bus.awaddr = 32'h28; bus.awlen = 8'd0; bus.awsize = 3'd3;
        bus.awburst = INCR; bus.awvalid = 1'b1;
        @(posedge clk); #1;
        bus.awvalid = 1'b0;
        bus.wvalid = 1'b1; bus.wdata = 64'h5555; bus.wstrb = 8'hFF; bus.wlast = 1'b1;
        bus.arid = 8'hCD; bus.araddr = 32'h28; bus.arlen = 8'd0; bus.arsize = 3'd3;
        bus.arburst = INCR; bus.arvalid = 1'b1;
        @(negedge clk);
        check("coll wready", {63'd0, bus.wready}, 64'd1);
        check("coll arready", {63'd0, bus.arready}, 64'd1);
        @(posedge clk); #1;
        bus.wvalid = 1'b0; bus.wlast = 1'b0; bus.arvalid = 1'b0;
        @(negedge clk);
        check("coll rvalid", {63'd0, bus.rvalid}, 64'd1);
        check("coll rdata old", bus.rdata, 64'hFFFF_FFFF_0000_0005);
        check("coll bvalid", {63'd0, bus.bvalid}, 64'd1);
        check("coll bresp", {62'd0, bus.bresp}, 64'd0);
        bus.rready = 1'b1; bus.bready = 1'b1;
        @(posedge clk); #1;
        bus.rready = 1'b0; bus.bready = 1'b0;
        exp_q[0] = 64'h5555;
        axi_read("coll new", 8'hEF, 32'h28, 8'd0, INCR, OKAY);

        // Reset in the middle of a write burst and a stalled read burst
        @(negedge clk);
        bus.awid = 8'h12; bus.awaddr = 32'h300; bus.awlen = 8'd7; bus.awsize = 3'd3;
        bus.awburst = INCR; bus.awvalid = 1'b1;
        @(posedge clk); #1;
        bus.awvalid = 1'b0;
        bus.wvalid = 1'b1; bus.wdata = 64'hCAFE_0000; bus.wstrb = 8'hFF; bus.wlast = 1'b0;
        bus.arid = 8'h34; bus.araddr = 32'h0; bus.arlen = 8'd7; bus.arsize = 3'd3;
        bus.arburst = INCR; bus.arvalid = 1'b1;
        @(posedge clk); #1;
        bus.arvalid = 1'b0;
        bus.wdata = 64'hCAFE_0001;
        @(posedge clk); #1;
        rst = 1'b1;
        bus.wvalid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("mid-rst bvalid", {63'd0, bus.bvalid}, 64'd0);
        check("mid-rst rvalid", {63'd0, bus.rvalid}, 64'd0);
        check("mid-rst awready", {63'd0, bus.awready}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.bready = 1'b1; bus.rready = 1'b1;
        @(negedge clk);
        check("after-rst awready", {63'd0, bus.awready}, 64'd1);
        check("after-rst arready", {63'd0, bus.arready}, 64'd1);
        check("after-rst wready", {63'd0, bus.wready}, 64'd0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("after-rst no B", {63'd0, bus.bvalid}, 64'd0);
            check("after-rst no R", {63'd0, bus.rvalid}, 64'd0);
        end
        bus.bready = 1'b0; bus.rready = 1'b0;
        exp_q[0] = 64'hCAFE_0000; exp_q[1] = 64'hCAFE_0001;
        axi_read("rst kept wr", 8'h56, 32'h300, 8'd1, INCR, OKAY);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
